// File: rtl/bucket_proc_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bucket_proc_mc                                                |
// | Function : per-channel token-bucket credit manager with almost-full,     |
// |            sequence-error and full-timeout flags                         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bucket_proc_mc #(
    parameter int                     CH_NUM      = 4,
    parameter int                     CH_WIDTH    = 2,
    parameter int                     DEPTH_WIDTH = 9,
    parameter logic [DEPTH_WIDTH-1:0] FIFO_DEPTH  = 9'h1ff,
    parameter int                     LEN_WIDTH   = 11,
    parameter int                     DATA_BWIDTH = 5,
    parameter logic [DEPTH_WIDTH-1:0] MAX_FRM_CNT = 9'd62,
    parameter logic [DEPTH_WIDTH-1:0] REV_LEN     = 9'd128,
    parameter int                     TO_WIDTH    = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CH_NUM*DEPTH_WIDTH-1:0] data_ff_waterline,
    input  logic                          bucket_inc_wr,
    input  logic [CH_WIDTH-1:0]           bucket_inc_ch,
    input  logic [LEN_WIDTH-1:0]          bucket_inc_wdata,
    input  logic                          bucket_dec_wr,
    input  logic [CH_WIDTH-1:0]           bucket_dec_ch,
    input  logic [DEPTH_WIDTH-1:0]        bucket_dec_data,
    input  logic                          bucket_dec_wend,
    input  logic                          pulse_1ms,
    input  logic [TO_WIDTH-1:0]           cfg_to_thr,
    input  logic                          err_clr,
    output logic [CH_NUM*DEPTH_WIDTH-1:0] bucket_inc_cnt,
    output logic [CH_NUM-1:0]             bucket_af,
    output logic [CH_NUM-1:0]             bucket_err,
    output logic [CH_NUM-1:0]             bucket_full_time_over,
    output logic                          bucket_ch_err
);

    localparam logic [DEPTH_WIDTH-1:0] c_fifo_size = FIFO_DEPTH - MAX_FRM_CNT - REV_LEN;
    localparam logic [DEPTH_WIDTH-1:0] c_aff_wl    = FIFO_DEPTH - MAX_FRM_CNT;

    logic [DEPTH_WIDTH-1:0] w_inc_pre;
    logic                   w_inc_ok;
    logic                   w_dec_ok;
    logic                   w_to_off;
    logic                   r_ch_err;

    // Frame length in bytes rounded up to whole FIFO words.
    assign w_inc_pre = DEPTH_WIDTH'(bucket_inc_wdata[LEN_WIDTH-1:DATA_BWIDTH])
                     + DEPTH_WIDTH'(|bucket_inc_wdata[DATA_BWIDTH-1:0]);

    assign w_inc_ok = 32'(bucket_inc_ch) < CH_NUM;
    assign w_dec_ok = 32'(bucket_dec_ch) < CH_NUM;
    assign w_to_off = ~|cfg_to_thr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch_err <= 1'b0;
        end else begin
            r_ch_err <= (bucket_inc_wr & ~w_inc_ok) | (bucket_dec_wr & ~w_dec_ok)
                      | (r_ch_err & ~err_clr);
        end
    end

    assign bucket_ch_err = r_ch_err;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic [DEPTH_WIDTH-1:0] w_wl;
        logic [DEPTH_WIDTH-1:0] w_used;
        logic [DEPTH_WIDTH-1:0] w_allow;
        logic [DEPTH_WIDTH-1:0] w_onway;
        logic                   w_inc_hit;
        logic                   w_dec_hit;
        logic                   w_seq_bad;
        logic                   w_to_clr;
        logic [DEPTH_WIDTH-1:0] r_inc_cnt;
        logic [DEPTH_WIDTH-1:0] r_dec_cnt;
        logic [TO_WIDTH-1:0]    r_to_cnt;
        logic                   r_af;
        logic                   r_err;
        logic                   r_tover;

        assign w_wl      = data_ff_waterline[n*DEPTH_WIDTH +: DEPTH_WIDTH];
        assign w_inc_hit = bucket_inc_wr & w_inc_ok & (bucket_inc_ch == CH_WIDTH'(n));
        assign w_dec_hit = bucket_dec_wr & w_dec_ok & (bucket_dec_ch == CH_WIDTH'(n));

        // Above the almost-full waterline the FIFO is treated as completely used.
        assign w_used    = (w_wl < c_aff_wl) ? (w_wl + MAX_FRM_CNT) : '1;
        assign w_allow   = (c_fifo_size > w_used) ? (c_fifo_size - w_used) : '0;
        assign w_onway   = r_inc_cnt - r_dec_cnt;

        assign w_seq_bad = w_dec_hit & bucket_dec_wend
                         & (bucket_dec_data != (r_dec_cnt + DEPTH_WIDTH'(1)));
        assign w_to_clr  = w_dec_hit | ~r_af | w_to_off;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_inc_cnt <= '0;
                r_dec_cnt <= '0;
                r_to_cnt  <= '0;
                r_af      <= 1'b0;
                r_err     <= 1'b0;
                r_tover   <= 1'b0;
            end else begin
                if (w_inc_hit) begin
                    r_inc_cnt <= r_inc_cnt + w_inc_pre;
                end
                if (w_dec_hit) begin
                    r_dec_cnt <= r_dec_cnt + DEPTH_WIDTH'(1);
                end
                r_af  <= (w_onway >= w_allow);
                r_err <= w_seq_bad | (r_err & ~err_clr);
                if (w_to_clr) begin
                    r_to_cnt <= '0;
                end else if (pulse_1ms && (r_to_cnt < cfg_to_thr)) begin
                    r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                end
                // Clearing conditions drop time_over on the same edge that clears the count.
                r_tover <= ~w_to_clr & (r_to_cnt == cfg_to_thr);
            end
        end

        assign bucket_inc_cnt[n*DEPTH_WIDTH +: DEPTH_WIDTH] = r_inc_cnt;
        assign bucket_af[n]             = r_af;
        assign bucket_err[n]            = r_err;
        assign bucket_full_time_over[n] = r_tover;
    end

endmodule
`default_nettype wire
